// File: rtl/bch_decode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bch_decode_ctrl : BCH(31,k,T=3) decode sequencer (syndrome -> BM -> Chien)
// Rev 1.0
// ---------------------------------------------------------------------------
module bch_decode_ctrl #(
   parameter int N          = 31,
   parameter int m          = 5,
   parameter int T          = 3,
   parameter int BM_TIMEOUT = 64,
   parameter int CS_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_word,
   output logic [N-1:0]     syn_r,
   input  logic [2*T*m-1:0] syndromes,
   output logic             bm_reset,
   input  logic             bm_done,
   input  logic [3:0]       bm_L,
   output logic             cs_start,
   input  logic             cs_done,
   input  logic [3:0]       cs_root_cnt,
   input  logic [N-1:0]     cs_err_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_word,
   output logic [3:0]       out_nerr,
   output logic             out_fail,
   output logic             busy
);

   localparam int TMAX = (BM_TIMEOUT > CS_TIMEOUT) ? BM_TIMEOUT : CS_TIMEOUT;
   localparam int CW   = (TMAX > 2) ? $clog2(TMAX) : 1;
   localparam logic [CW-1:0] BM_LAST = CW'(BM_TIMEOUT - 1);
   localparam logic [CW-1:0] CS_LAST = CW'(CS_TIMEOUT - 1);
   localparam logic [3:0]    T_L     = 4'(T);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SYN      = 3'd1,
      BM_RST   = 3'd2,
      BM_WAIT  = 3'd3,
      CS_START = 3'd4,
      CS_WAIT  = 3'd5,
      OUT      = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  syn_q, syn_d;
   logic [N-1:0]  word_q, word_d;
   logic [3:0]    nerr_q, nerr_d;
   logic [3:0]    l_q, l_d;
   logic          fail_q, fail_d;
   logic          valid_q, valid_d;
   logic          cs_start_q, cs_start_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d    = state_q;
      syn_d      = syn_q;
      word_d     = word_q;
      nerr_d     = nerr_q;
      l_d        = l_q;
      fail_d     = fail_q;
      valid_d    = valid_q;
      cs_start_d = 1'b0;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               syn_d   = in_word;
               cnt_d   = '0;
               state_d = SYN;
            end
         end
         SYN: begin
            if (syndromes == '0) begin
               word_d  = syn_q;
               nerr_d  = 4'd0;
               fail_d  = 1'b0;
               valid_d = 1'b1;
               state_d = OUT;
            end else begin
               state_d = BM_RST;
            end
         end
         BM_RST: begin
            state_d = BM_WAIT;
         end
         BM_WAIT: begin
            // A done arriving on the timeout edge still takes the success path.
            if (bm_done) begin
               l_d = bm_L;
               if ((bm_L > T_L) || (bm_L == 4'd0)) begin
                  word_d  = syn_q;
                  nerr_d  = bm_L;
                  fail_d  = 1'b1;
                  valid_d = 1'b1;
                  state_d = OUT;
               end else begin
                  cs_start_d = 1'b1;
                  state_d    = CS_START;
               end
            end else if (cnt_q == BM_LAST) begin
               word_d  = syn_q;
               nerr_d  = 4'd0;
               fail_d  = 1'b1;
               valid_d = 1'b1;
               state_d = OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CS_START: begin
            cnt_d   = '0;
            state_d = CS_WAIT;
         end
         CS_WAIT: begin
            if (cs_done) begin
               nerr_d  = l_q;
               valid_d = 1'b1;
               state_d = OUT;
               if (cs_root_cnt == l_q) begin
                  word_d = syn_q ^ cs_err_mask;
                  fail_d = 1'b0;
               end else begin
                  word_d = syn_q;
                  fail_d = 1'b1;
               end
            end else if (cnt_q == CS_LAST) begin
               word_d  = syn_q;
               nerr_d  = l_q;
               fail_d  = 1'b1;
               valid_d = 1'b1;
               state_d = OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         syn_q      <= '0;
         word_q     <= '0;
         nerr_q     <= '0;
         l_q        <= '0;
         fail_q     <= 1'b0;
         valid_q    <= 1'b0;
         cs_start_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         syn_q      <= syn_d;
         word_q     <= word_d;
         nerr_q     <= nerr_d;
         l_q        <= l_d;
         fail_q     <= fail_d;
         valid_q    <= valid_d;
         cs_start_q <= cs_start_d;
         cnt_q      <= cnt_d;
      end
   end

   // BM stays in reset until the syndromes are known to be non-zero.
   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign bm_reset  = (state_q == IDLE) || (state_q == SYN) || (state_q == BM_RST);
   assign syn_r     = syn_q;
   assign cs_start  = cs_start_q;
   assign out_valid = valid_q;
   assign out_word  = word_q;
   assign out_nerr  = nerr_q;
   assign out_fail  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_bch_decode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bch_decode_ctrl : randomized self-checking bench for bch_decode_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bch_decode_ctrl;
   localparam int N   = 31;
   localparam int M   = 5;
   localparam int T   = 3;
   localparam int BMT = 64;
   localparam int CST = 64;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N-1:0]     in_word = '0;
   logic [N-1:0]     syn_r;
   logic [2*T*M-1:0] syndromes;
   logic             bm_reset;
   logic             bm_done = 1'b0;
   logic [3:0]       bm_L = '0;
   logic             cs_start;
   logic             cs_done = 1'b0;
   logic [3:0]       cs_root_cnt = '0;
   logic [N-1:0]     cs_err_mask = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [N-1:0]     out_word;
   logic [3:0]       out_nerr;
   logic             out_fail;
   logic             busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bch_decode_ctrl #(.N(N), .m(M), .T(T), .BM_TIMEOUT(BMT), .CS_TIMEOUT(CST)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
      .syn_r(syn_r), .syndromes(syndromes),
      .bm_reset(bm_reset), .bm_done(bm_done), .bm_L(bm_L),
      .cs_start(cs_start), .cs_done(cs_done), .cs_root_cnt(cs_root_cnt), .cs_err_mask(cs_err_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
      .out_nerr(out_nerr), .out_fail(out_fail), .busy(busy)
   );

   // GF(2^5), primitive polynomial x^5 + x^2 + 1
   function automatic logic [4:0] gf_pow(input int e);
      logic [5:0] x;
      x = 6'd1;
      for (int k = 0; k < e; k++) begin
         x = x << 1;
         if (x[5]) x = x ^ 6'b100101;
      end
      return x[4:0];
   endfunction

   // S_j = r(alpha^j), j = 1..2T
   function automatic logic [2*T*M-1:0] syn_calc(input logic [N-1:0] r);
      logic [2*T*M-1:0] s;
      logic [4:0]       acc;
      s = '0;
      for (int j = 1; j <= 2*T; j++) begin
         acc = '0;
         for (int i = 0; i < N; i++)
            if (r[i]) acc = acc ^ gf_pow((i * j) % 31);
         s[(j-1)*M +: M] = acc;
      end
      return s;
   endfunction

   assign syndromes = syn_calc(syn_r);

   // Reference: outcome of one word given the responder behaviour.
   // d/e = idle edges before done (negative = never); lat = edges after accept.
   function automatic void model(input logic [N-1:0] w, input int d, input logic [3:0] L,
                                 input int e, input logic [3:0] rc, input logic [N-1:0] mask,
                                 output logic [N-1:0] xw, output int xn, output bit xf,
                                 output int xl, output int xp);
      xw = w; xn = -1; xf = 1'b1; xp = 0;
      if (syn_calc(w) == '0) begin
         xn = 0; xf = 1'b0; xl = 1;
      end else if (d < 0 || d >= BMT) begin
         xn = 0; xl = 2 + BMT;
      end else if (L == 0 || L > T) begin
         xl = d + 3;
      end else if (e < 0 || e >= CST) begin
         xp = 1; xl = d + 4 + CST;
      end else begin
         xp = 1; xl = d + e + 5; xn = L;
         if (rc == L) begin
            xw = w ^ mask; xf = 1'b0;
         end
      end
   endfunction

   int          obs_lat, obs_pulses;
   bit          obs_bm_low, obs_acc_ready, obs_stable, obs_hold_ok, obs_after_valid, obs_after_ready;
   logic [N-1:0] obs_word;
   logic [3:0]  obs_nerr;
   logic        obs_fail;

   // Drives one word and plays the BM and Chien responders; records observations.
   task automatic run_word(input logic [N-1:0] w, input int d, input logic [3:0] L, input int e,
                           input logic [3:0] rc, input logic [N-1:0] mask, input int hold,
                           input bit noise, input int abort_at);
      int bmc, csc;
      bit armed;
      bmc = 0; csc = 0; armed = 0;
      obs_lat = -1; obs_pulses = 0; obs_bm_low = 0; obs_stable = 1; obs_hold_ok = 1;
      @(negedge clk);
      in_valid = 1'b1; in_word = w; bm_L = L; cs_root_cnt = rc; cs_err_mask = mask;
      bm_done = noise; cs_done = noise;
      obs_acc_ready = in_ready;
      @(posedge clk);
      for (int i = 0; i < 400 && obs_lat < 0; i++) begin
         @(negedge clk);
         if (i == 0) in_valid = 1'b0;
         if (out_valid) begin
            obs_lat = i;
         end else begin
            if (!bm_reset) obs_bm_low = 1;
            if (bm_reset) begin
               bmc = 0; bm_done = noise;
            end else begin
               bmc++; bm_done = (d >= 0) && (bmc >= d + 1);
            end
            if (cs_start) begin
               obs_pulses++; armed = 1; csc = 0; cs_done = 1'b0;
            end else if (armed) begin
               csc++; cs_done = (e >= 0) && (csc == e + 1);
               if (cs_done) armed = 0;
            end else begin
               cs_done = noise;
            end
            if (i == abort_at) begin
               reset_n = 1'b0; bm_done = 1'b0; cs_done = 1'b0;
               return;
            end
            @(posedge clk);
         end
      end
      cs_done = 1'b0;
      obs_word = out_word; obs_nerr = out_nerr; obs_fail = out_fail;
      if (hold > 0) begin
         in_valid = 1'b1; in_word = ~w;
      end
      repeat (hold) begin
         @(posedge clk); @(negedge clk);
         if (out_valid !== 1'b1 || out_word !== obs_word || out_nerr !== obs_nerr ||
             out_fail !== obs_fail || syn_r !== w) obs_stable = 0;
         if (in_ready !== 1'b0 || busy !== 1'b1) obs_hold_ok = 0;
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0; bm_done = 1'b0; cs_done = 1'b0;
      obs_after_valid = out_valid;
      obs_after_ready = in_ready;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({in_ready, busy, bm_reset, cs_start, out_valid, out_nerr, out_fail} !== 10'b1_0_1_0_0_0000_0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected %b",
                  {in_ready, busy, bm_reset, cs_start, out_valid, out_nerr, out_fail}, 10'b1010000000);
      end
      n_tests++;
      if (syn_r !== '0 || out_word !== '0) begin
         n_fail++; $display("FAIL reset_words: got syn_r=%h out_word=%h expected 0/0", syn_r, out_word);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_clean;
      run_word('0, 0, 4'd0, 0, 4'd0, '0, 0, 1'b1, -1);
      n_tests++;
      if (obs_lat !== 1) begin n_fail++; $display("FAIL clean_latency: got %0d expected 1", obs_lat); end
      n_tests++;
      if ({obs_word, obs_nerr, obs_fail} !== {31'd0, 4'd0, 1'b0}) begin
         n_fail++; $display("FAIL clean_result: got word=%h nerr=%0d fail=%b expected 0/0/0", obs_word, obs_nerr, obs_fail);
      end
      n_tests++;
      if (obs_bm_low !== 1'b0 || obs_pulses !== 0) begin
         n_fail++; $display("FAIL clean_no_bm_cs: got bm_low=%b pulses=%0d expected 0/0", obs_bm_low, obs_pulses);
      end
      n_tests++;
      if (obs_acc_ready !== 1'b1 || obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
         n_fail++; $display("FAIL clean_handshake: got %b%b%b expected 101", obs_acc_ready, obs_after_valid, obs_after_ready);
      end
   endtask

   task automatic test_single_error;
      run_word(31'h20, 9, 4'd1, 3, 4'd1, 31'h20, 0, 1'b1, -1);
      n_tests++;
      if (obs_lat !== 17) begin n_fail++; $display("FAIL single_latency: got %0d expected 17", obs_lat); end
      n_tests++;
      if ({obs_word, obs_nerr, obs_fail} !== {31'd0, 4'd1, 1'b0}) begin
         n_fail++; $display("FAIL single_result: got word=%h nerr=%0d fail=%b expected 0/1/0", obs_word, obs_nerr, obs_fail);
      end
      n_tests++;
      if (obs_pulses !== 1 || obs_bm_low !== 1'b1) begin
         n_fail++; $display("FAIL single_cs_pulse: got pulses=%0d bm_low=%b expected 1/1", obs_pulses, obs_bm_low);
      end
   endtask

   task automatic test_uncorrectable;
      run_word(31'h1234, 0, 4'd4, 0, 4'd4, 31'h7, 0, 1'b0, -1);
      n_tests++;
      if ({obs_word, obs_fail} !== {31'h1234, 1'b1} || obs_pulses !== 0 || obs_lat !== 3) begin
         n_fail++; $display("FAIL uncorr_L4: got word=%h fail=%b pulses=%0d lat=%0d expected 1234/1/0/3",
                            obs_word, obs_fail, obs_pulses, obs_lat);
      end
      run_word(31'h0404, 1, 4'd2, 2, 4'd1, 31'h0404, 0, 1'b0, -1);
      n_tests++;
      if ({obs_word, obs_nerr, obs_fail} !== {31'h0404, 4'd2, 1'b1} || obs_lat !== 8) begin
         n_fail++; $display("FAIL uncorr_rootcnt: got word=%h nerr=%0d fail=%b lat=%0d expected 404/2/1/8",
                            obs_word, obs_nerr, obs_fail, obs_lat);
      end
   endtask

   task automatic test_timeouts;
      run_word(31'h20, -1, 4'd1, 0, 4'd1, 31'h20, 0, 1'b0, -1);
      n_tests++;
      if (obs_lat !== 2 + BMT || {obs_word, obs_nerr, obs_fail} !== {31'h20, 4'd0, 1'b1}) begin
         n_fail++; $display("FAIL bm_timeout: got lat=%0d word=%h nerr=%0d fail=%b expected %0d/20/0/1",
                            obs_lat, obs_word, obs_nerr, obs_fail, 2 + BMT);
      end
      run_word(31'h20, 0, 4'd1, -1, 4'd1, 31'h20, 0, 1'b0, -1);
      n_tests++;
      if (obs_lat !== 4 + CST || {obs_word, obs_fail} !== {31'h20, 1'b1} || obs_pulses !== 1) begin
         n_fail++; $display("FAIL cs_timeout: got lat=%0d word=%h fail=%b pulses=%0d expected %0d/20/1/1",
                            obs_lat, obs_word, obs_fail, obs_pulses, 4 + CST);
      end
      run_word(31'h20, BMT - 1, 4'd1, 0, 4'd1, 31'h20, 0, 1'b0, -1);
      n_tests++;
      if (obs_lat !== BMT + 4 || {obs_word, obs_nerr, obs_fail} !== {31'd0, 4'd1, 1'b0}) begin
         n_fail++; $display("FAIL bm_done_on_timeout: got lat=%0d word=%h nerr=%0d fail=%b expected %0d/0/1/0",
                            obs_lat, obs_word, obs_nerr, obs_fail, BMT + 4);
      end
      run_word(31'h20, 0, 4'd1, CST - 1, 4'd1, 31'h20, 0, 1'b0, -1);
      n_tests++;
      if (obs_lat !== CST + 4 || {obs_word, obs_nerr, obs_fail} !== {31'd0, 4'd1, 1'b0}) begin
         n_fail++; $display("FAIL cs_done_on_timeout: got lat=%0d word=%h nerr=%0d fail=%b expected %0d/0/1/0",
                            obs_lat, obs_word, obs_nerr, obs_fail, CST + 4);
      end
   endtask

   task automatic test_backpressure;
      run_word(31'h4001, 2, 4'd2, 1, 4'd2, 31'h4001, 5, 1'b0, -1);
      n_tests++;
      if ({obs_word, obs_nerr, obs_fail} !== {31'd0, 4'd2, 1'b0}) begin
         n_fail++; $display("FAIL bp_result: got word=%h nerr=%0d fail=%b expected 0/2/0", obs_word, obs_nerr, obs_fail);
      end
      n_tests++;
      if (obs_stable !== 1'b1 || obs_hold_ok !== 1'b1) begin
         n_fail++; $display("FAIL bp_stable: got stable=%b inready_low=%b expected 1/1", obs_stable, obs_hold_ok);
      end
      n_tests++;
      if (obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got valid=%b in_ready=%b expected 0/1", obs_after_valid, obs_after_ready);
      end
   endtask

   task automatic test_reset_midop;
      run_word(31'h80, 2, 4'd1, -1, 4'd1, 31'h80, 0, 1'b0, 10);
      #1;
      n_tests++;
      if ({in_ready, busy, bm_reset, cs_start, out_valid, out_nerr, out_fail} !== 10'b1_0_1_0_0_0000_0 ||
          syn_r !== '0 || out_word !== '0) begin
         n_fail++; $display("FAIL midop_reset: got flags=%b syn_r=%h out_word=%h expected 1010000000/0/0",
                            {in_ready, busy, bm_reset, cs_start, out_valid, out_nerr, out_fail}, syn_r, out_word);
      end
      @(posedge clk); @(negedge clk);
      reset_n = 1'b1;
      run_word('1, 0, 4'd0, 0, 4'd0, '0, 0, 1'b0, -1);
      n_tests++;
      if (obs_lat !== 1 || {obs_word, obs_nerr, obs_fail} !== {{N{1'b1}}, 4'd0, 1'b0}) begin
         n_fail++; $display("FAIL midop_after: got lat=%0d word=%h nerr=%0d fail=%b expected 1/7fffffff/0/0",
                            obs_lat, obs_word, obs_nerr, obs_fail);
      end
   endtask

   task automatic test_random;
      logic [N-1:0] w, mask, xw;
      logic [3:0]   L, rc;
      int           d, e, hold, xn, xl, xp;
      bit           xf, noise;
      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 5))
            0:       w = ($urandom_range(0, 1) == 0) ? '0 : '1;
            1:       w = N'(1) << $urandom_range(0, N - 1);
            default: w = N'($urandom);
         endcase
         case ($urandom_range(0, 7))
            0:       d = -1;
            1:       d = BMT - 1;
            default: d = $urandom_range(0, 8);
         endcase
         case ($urandom_range(0, 7))
            0:       e = -1;
            1:       e = CST - 1;
            default: e = $urandom_range(0, 8);
         endcase
         L     = 4'($urandom_range(0, 5));
         rc    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : L;
         mask  = N'($urandom);
         hold  = $urandom_range(0, 3);
         noise = 1'($urandom_range(0, 1));
         model(w, d, L, e, rc, mask, xw, xn, xf, xl, xp);
         run_word(w, d, L, e, rc, mask, hold, noise, -1);
         n_tests++;
         if (obs_lat !== xl) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", k, obs_lat, xl); end
         n_tests++;
         if (obs_word !== xw || obs_fail !== xf) begin
            n_fail++; $display("FAIL rand%0d_result: got word=%h fail=%b expected %h/%b", k, obs_word, obs_fail, xw, xf);
         end
         if (xn >= 0) begin
            n_tests++;
            if (obs_nerr !== 4'(xn)) begin n_fail++; $display("FAIL rand%0d_nerr: got %0d expected %0d", k, obs_nerr, xn); end
         end
         n_tests++;
         if (obs_pulses !== xp) begin n_fail++; $display("FAIL rand%0d_cs_pulses: got %0d expected %0d", k, obs_pulses, xp); end
         n_tests++;
         if (obs_stable !== 1'b1 || obs_hold_ok !== 1'b1 || obs_after_valid !== 1'b0 || obs_after_ready !== 1'b1) begin
            n_fail++; $display("FAIL rand%0d_handshake: got %b%b%b%b expected 1101", k,
                               obs_stable, obs_hold_ok, obs_after_valid, obs_after_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single_error();
      test_uncorrectable();
      test_timeouts();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/bch_decode_ctrl.md
# bch_decode_ctrl

Sequencer for the BCH(31,k,T=3) decode datapath. Captures a received word through a valid/ready handshake and drives it onto `syndromeCalc`. It then resets and releases `BerlMassV2`, launches an external Chien search unit, applies the returned error mask, and returns the corrected word with an error count and a fail flag. The block sits between the upstream word source and the downstream consumer and owns the only copy of the word in flight.

## Interface
- `N`, 31: codeword length.
- `m`, 5: GF(2^m) symbol width.
- `T`, 3: correction capability; `2*T` syndromes.
- `BM_TIMEOUT`, 64: max cycles in BM_WAIT before declaring failure.
- `CS_TIMEOUT`, 64: max cycles in CS_WAIT before declaring failure.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  block can accept a word.
- `in_word`  in  N  received word.
- `syn_r`  out  N  registered word, drives `syndromeCalc.r`.
- `syndromes`  in  2*T*m  {S6..S1} from `syndromeCalc`; S1 in bits [m-1:0].
- `bm_reset`  out  1  active-high reset to `BerlMassV2`.
- `bm_done`  in  1  `BerlMassV2` done.
- `bm_L`  in  4  `BerlMassV2` locator degree L.
- `cs_start`  out  1  one-cycle Chien search start pulse.
- `cs_done`  in  1  Chien search complete.
- `cs_root_cnt`  in  4  number of roots found.
- `cs_err_mask`  in  N  bit i set means error at position i.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_word`  out  N  corrected word, or the raw word on fail.
- `out_nerr`  out  4  corrected error count (L).
- `out_fail`  out  1  uncorrectable or timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SYN, BM_RST, BM_WAIT, CS_START, CS_WAIT, OUT.
- IDLE
  - `in_ready`=1.
  - On `in_valid&&in_ready`: register `in_word` into `syn_r`, clear the timeout counter, go to SYN.
- SYN (1 cycle)
  - Syndromes are combinational from `syn_r` and are sampled on this edge.
  - All 2T syndromes zero: `out_word`=`syn_r`, `out_nerr`=0, `out_fail`=0, go to OUT.
  - Otherwise go to BM_RST.
- BM_RST (1 cycle): go to BM_WAIT.
- `bm_reset`=1 in IDLE, SYN and BM_RST; 0 in BM_WAIT, CS_START, CS_WAIT and OUT. Sigma is held for Chien and is only cleared on return to IDLE.
- BM_WAIT
  - `bm_done` is sampled only in this state; any earlier value is ignored.
  - On `bm_done`: latch `bm_L`. If L>T or L==0, go to OUT with fail. Otherwise go to CS_START.
  - If the counter reaches `BM_TIMEOUT-1` with no done: go to OUT with fail, nerr=0.
- CS_START (1 cycle): `cs_start`=1, clear the counter, go to CS_WAIT.
- CS_WAIT
  - On `cs_done`:
    - If `cs_root_cnt`==L: `out_word`=`syn_r ^ cs_err_mask`, nerr=L, fail=0.
    - Otherwise: `out_word`=`syn_r`, nerr=L, fail=1.
  - If the counter reaches `CS_TIMEOUT-1` with no done: fail.
  - Either outcome goes to OUT.
- On every fail path: `out_word`=`syn_r` (uncorrected), `out_fail`=1.
- OUT
  - `out_valid`=1; `out_word`, `out_nerr` and `out_fail` are held stable.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 in OUT, so there is no overlap with a new word.
- Done versus timeout on the same edge: done wins.
- `cs_done` or `bm_done` arriving in any other state: ignored.

## Timing
- Reset values: state IDLE, `in_ready`=1, `busy`=0, `bm_reset`=1, `cs_start`=0, `out_valid`=0, `syn_r`=0, `out_word`=0, `out_nerr`=0, `out_fail`=0.
- Asserting `reset_n` mid-operation aborts immediately: the word is dropped and all outputs return to reset values.
- Handshakes complete on a rising edge where valid&&ready. Outputs are registered except `in_ready`, `busy` and `bm_reset`, which decode directly from state.
- Clean-word latency: accept at edge E0, `out_valid` high after E1 (2 edges from accept to result).
- Error-path latency: `bm_reset` falls after E2. `bm_done` sampled at edge Eb means `cs_start` is high for the cycle after Eb. `cs_done` at edge Ec means `out_valid` is high after Ec.
- Minimum `bm_reset` high time before release: 2 cycles (SYN plus BM_RST).
- Back-to-back throughput: one word per (latency + 1) cycles; IDLE occupies at least 1 cycle between words.

## Test plan
- Clean word: `in_word`=0 → `out_valid` 2 cycles after accept; `out_word`=0, nerr=0, fail=0; `bm_reset` never deasserts; `cs_start` never pulses.
- Single error: `in_word`=32'h20 (bit 5) with real `syndromeCalc`; BM model asserts done with L=1 after 10 cycles; Chien model returns mask 1<<5, root_cnt=1 → `out_word`=0, nerr=1, fail=0, exactly one `cs_start` pulse.
- Uncorrectable: BM model returns L=4 → OUT with fail=1, `out_word`=`in_word`, no `cs_start`. Second case: L=2 with root_cnt=1 → fail=1, nerr=2, `out_word`=`in_word`.
- Timeouts: `bm_done` held 0 → fail=1 and `out_valid` exactly `BM_TIMEOUT` cycles after BM_WAIT entry. Repeat with `cs_done` held 0 against `CS_TIMEOUT`. Done on the timeout edge → success.
- Backpressure: `out_ready`=0 for 5 cycles → `out_valid`, `out_word` and flags stable; `in_ready`=0 throughout; new word accepted only after IDLE.
- Reset mid-op: drop `reset_n` during CS_WAIT → outputs at reset values immediately; `bm_reset`=1; a following clean word decodes normally.
